// File: rtl/tx_frame_gen.sv
// tx_frame_gen: transmit frame generator.
// On an accepted start it snapshots the 96-bit address word and a clamped payload
// length. It then streams one Ethernet frame, one byte per handshake, on a byte-wide
// AXI4-Stream master. The byte order is: destination MAC, source MAC, 2-byte length,
// then an incrementing payload that is zero-padded up to MIN_PAYLOAD.
// FCS and preamble are left to the MAC.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start             one-cycle send request, honoured only in IDLE
//   payload_len[15:0] requested payload byte count (clamped to MAX_PAYLOAD)
//   tx_address[95:0]  [95:48] source MAC, [47:0] destination MAC
//   busy              high from accepted start until the inter-frame gap ends
//   done              one-cycle pulse after the tlast handshake
//   m_axis_*          byte stream toward the MAC TX client
//
// state | meaning
// IDLE  | waiting for start
// DST   | sending destination MAC, 6 bytes
// SRC   | sending source MAC, 6 bytes
// LEN   | sending length field, 2 bytes
// PAY   | sending payload + zero padding
// GAP   | inter-frame gap countdown; start ignored
module tx_frame_gen #(
    parameter logic [7:0] PAT_SEED    = 8'h00,
    parameter int         IFG_CYCLES  = 12,
    parameter int         MAX_PAYLOAD = 1500,
    parameter int         MIN_PAYLOAD = 46
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] payload_len,
    input  logic [95:0] tx_address,
    output logic        busy,
    output logic        done,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DST,
        ST_SRC,
        ST_LEN,
        ST_PAY,
        ST_GAP
    } state_t;

    localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD);
    localparam logic [15:0] MIN_LEN = 16'(MIN_PAYLOAD);
    localparam logic [7:0]  IFG_LEN = 8'(IFG_CYCLES);

    state_t      state_q, state_d;
    logic [95:0] addr_q, addr_d;
    logic [15:0] len_q, len_d;
    logic [10:0] cnt_q, cnt_d;
    logic [7:0]  gap_q, gap_d;
    logic [7:0]  tdata_q, tdata_d;
    logic        tvalid_q, tvalid_d;
    logic        tlast_q, tlast_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        hs;
    logic        load_byte;
    logic [15:0] pay_total_d;

    assign hs = tvalid_q & m_axis_tready;

    // Byte presented at position (st, cnt) of the frame.
    function automatic logic [7:0] frame_byte(input state_t st, input logic [10:0] cnt,
                                              input logic [95:0] addr, input logic [15:0] len);
        logic [7:0] b;
        b = 8'h00;
        case (st)
            ST_DST: begin
                case (cnt[2:0])
                    3'd0:    b = addr[47:40];
                    3'd1:    b = addr[39:32];
                    3'd2:    b = addr[31:24];
                    3'd3:    b = addr[23:16];
                    3'd4:    b = addr[15:8];
                    3'd5:    b = addr[7:0];
                    default: b = 8'h00;
                endcase
            end
            ST_SRC: begin
                case (cnt[2:0])
                    3'd0:    b = addr[95:88];
                    3'd1:    b = addr[87:80];
                    3'd2:    b = addr[79:72];
                    3'd3:    b = addr[71:64];
                    3'd4:    b = addr[63:56];
                    3'd5:    b = addr[55:48];
                    default: b = 8'h00;
                endcase
            end
            ST_LEN:  b = cnt[0] ? len[7:0] : len[15:8];
            // Pattern wraps naturally in 8 bits; cnt keeps counting the full frame.
            ST_PAY:  b = ({5'd0, cnt} < len) ? (PAT_SEED + cnt[7:0]) : 8'h00;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            gap_q    <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        tdata_d   = tdata_q;
        tvalid_d  = tvalid_q;
        tlast_d   = tlast_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        load_byte = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d    = tx_address;
                    len_d     = (payload_len > MAX_LEN) ? MAX_LEN : payload_len;
                    cnt_d     = '0;
                    state_d   = ST_DST;
                    tvalid_d  = 1'b1;
                    busy_d    = 1'b1;
                    load_byte = 1'b1;
                end
            end
            ST_DST: begin
                if (hs) begin
                    load_byte = 1'b1;
                    if (cnt_q == 11'd5) begin
                        state_d = ST_SRC;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 11'd1;
                    end
                end
            end
            ST_SRC: begin
                if (hs) begin
                    load_byte = 1'b1;
                    if (cnt_q == 11'd5) begin
                        state_d = ST_LEN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 11'd1;
                    end
                end
            end
            ST_LEN: begin
                if (hs) begin
                    load_byte = 1'b1;
                    if (cnt_q == 11'd1) begin
                        state_d = ST_PAY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 11'd1;
                    end
                end
            end
            ST_PAY: begin
                if (hs) begin
                    if (tlast_q) begin
                        done_d   = 1'b1;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        tdata_d  = 8'h00;
                        cnt_d    = '0;
                        // The done cycle itself counts as the first gap cycle.
                        if (IFG_LEN == 8'd0) begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                        end else begin
                            state_d = ST_GAP;
                            gap_d   = IFG_LEN - 8'd1;
                        end
                    end else begin
                        load_byte = 1'b1;
                        cnt_d     = cnt_q + 11'd1;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == 8'd0) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
                busy_d   = 1'b0;
            end
        endcase

        pay_total_d = (len_d < MIN_LEN) ? MIN_LEN : len_d;

        if (load_byte) begin
            tdata_d = frame_byte(state_d, cnt_d, addr_d, len_d);
            tlast_d = (state_d == ST_PAY) && ({5'd0, cnt_d} == (pay_total_d - 16'd1));
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;

endmodule

// File: tb/tb_tx_frame_gen.sv
// Testbench for tx_frame_gen.
// dut_a uses the default parameters. dut_b uses PAT_SEED = 8'hF0 and IFG_CYCLES = 0.
// A select signal routes the shared stimulus to one of the two instances and picks
// that instance's outputs for checking.
module tb_tx_frame_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        ready;
    logic        sel;
    logic [15:0] len_i;
    logic [95:0] addr_i;

    logic        busy_a, done_a, tvalid_a, tlast_a;
    logic [7:0]  tdata_a;
    logic        busy_b, done_b, tvalid_b, tlast_b;
    logic [7:0]  tdata_b;
    logic        start_a, start_b;
    logic        busy_m, done_m, tvalid_m, tlast_m;
    logic [7:0]  tdata_m;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] got [0:2047];

    typedef struct {
        logic        sel;
        logic [95:0] addr;
        logic [15:0] len;
        int          ready_pct;
        int          exp_total;
        logic [15:0] exp_lenf;
        logic        inj;
    } vec_t;

    vec_t tbl [0:11];

    always #5 clk = ~clk;

    assign start_a  = start & ~sel;
    assign start_b  = start & sel;
    assign busy_m   = sel ? busy_b   : busy_a;
    assign done_m   = sel ? done_b   : done_a;
    assign tvalid_m = sel ? tvalid_b : tvalid_a;
    assign tlast_m  = sel ? tlast_b  : tlast_a;
    assign tdata_m  = sel ? tdata_b  : tdata_a;

    tx_frame_gen dut_a (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start_a),
        .payload_len   (len_i),
        .tx_address    (addr_i),
        .busy          (busy_a),
        .done          (done_a),
        .m_axis_tdata  (tdata_a),
        .m_axis_tvalid (tvalid_a),
        .m_axis_tready (ready),
        .m_axis_tlast  (tlast_a)
    );

    tx_frame_gen #(.PAT_SEED(8'hF0), .IFG_CYCLES(0)) dut_b (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start_b),
        .payload_len   (len_i),
        .tx_address    (addr_i),
        .busy          (busy_b),
        .done          (done_b),
        .m_axis_tdata  (tdata_b),
        .m_axis_tvalid (tvalid_b),
        .m_axis_tready (ready),
        .m_axis_tlast  (tlast_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected frame byte i, derived from the frame layout.
    function automatic logic [7:0] model_byte(input logic [95:0] a, input logic [15:0] len,
                                              input logic [7:0] seed, input int i);
        int l;
        int p;
        l = (len > 16'd1500) ? 1500 : int'(len);
        p = i - 14;
        if (i < 6)        return a[47 - 8*i -: 8];
        else if (i < 12)  return a[95 - 8*(i-6) -: 8];
        else if (i == 12) return 8'(l >> 8);
        else if (i == 13) return 8'(l);
        else              return (p < l) ? 8'(int'(seed) + p) : 8'h00;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input vec_t v);
        int   ifg_v, n, cyc, bad, first_bad, stall_bad, drop, last_bad, done_p, low_at, tv_gap;
        logic got_last, prev_stall, injected, prev_l;
        logic [7:0] prev_d, seed_v;
        seed_v = v.sel ? 8'hF0 : 8'h00;
        ifg_v  = v.sel ? 0 : 12;
        n = 0; cyc = 0; bad = 0; first_bad = -1; stall_bad = 0; drop = 0; last_bad = 0;
        done_p = 0; low_at = -1; tv_gap = 0;
        got_last = 1'b0; prev_stall = 1'b0; injected = 1'b0; prev_l = 1'b0; prev_d = 8'h00;

        sel = v.sel; addr_i = v.addr; len_i = v.len; ready = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        check("start_tvalid", 32'(tvalid_m), 32'd1);
        check("start_busy", 32'(busy_m), 32'd1);
        check("first_byte", 32'(tdata_m), 32'(v.addr[47:40]));

        while (!got_last && cyc < 6000) begin
            if (v.inj && !injected && n == 10) begin
                start = 1'b1; addr_i = ~v.addr; len_i = 16'd3; injected = 1'b1;
            end else begin
                start = 1'b0;
            end
            ready = (int'($urandom_range(99)) < v.ready_pct);
            if (prev_stall && (tdata_m !== prev_d || tlast_m !== prev_l)) stall_bad++;
            if (tvalid_m !== 1'b1) drop++;
            if (tvalid_m && ready) begin
                if (n < 2048) got[n] = tdata_m;
                if (tlast_m !== (n == v.exp_total - 1)) last_bad++;
                if (tlast_m) got_last = 1'b1;
                n++;
            end
            prev_stall = tvalid_m && !ready;
            prev_d = tdata_m;
            prev_l = tlast_m;
            step();
            cyc++;
        end
        start = 1'b0;
        ready = 1'b0;

        check("end_tvalid", 32'(tvalid_m), 32'd0);
        for (int k = 0; k <= ifg_v + 2; k++) begin
            if (done_m) done_p++;
            if (!busy_m && low_at < 0) low_at = k;
            if (k > 0 && tvalid_m) tv_gap++;
            start = (v.inj && k == 3);
            step();
        end
        start = 1'b0;

        for (int i = 0; i < n && i < 2048; i++) begin
            if (got[i] !== model_byte(v.addr, v.len, seed_v, i)) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
        end
        check("tlast_seen", 32'(got_last), 32'd1);
        check("byte_count", n, v.exp_total);
        check("byte_content_errors", bad, 0);
        if (bad != 0) $display("  first wrong byte at index %0d", first_bad);
        check("len_field", {16'd0, got[12], got[13]}, 32'(v.exp_lenf));
        check("stall_stable", stall_bad, 0);
        check("tvalid_held", drop, 0);
        check("tlast_position", last_bad, 0);
        check("done_pulses", done_p, 1);
        check("busy_low_cycle", low_at, ifg_v);
        check("gap_tvalid", tv_gap, 0);
    endtask

    task automatic check_basic_literal();
        logic [7:0] lit [0:15];
        lit = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h0A, 8'h0B,
                8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h00, 8'h32, 8'h00, 8'h01};
        for (int i = 0; i < 16; i++) check("basic_literal", 32'(got[i]), 32'(lit[i]));
        check("basic_last_byte", 32'(got[63]), 32'h31);
    endtask

    task automatic check_wrap_literal();
        check("wrap_first_pay", 32'(got[14]), 32'hF0);
        check("wrap_ff", 32'(got[29]), 32'hFF);
        check("wrap_00", 32'(got[30]), 32'h00);
        check("wrap_01", 32'(got[31]), 32'h01);
        check("wrap_last_byte", 32'(got[1513]), 32'hCB);
    endtask

    task automatic reset_mid_frame();
        int bad;
        sel = 1'b0; addr_i = {48'h665544332211, 48'hCAFEBABE0102}; len_i = 16'd30;
        ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        repeat (19) step();
        check("pre_reset_tvalid", 32'(tvalid_m), 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("reset_outputs", {20'd0, tvalid_m, tlast_m, done_m, busy_m, tdata_m}, 32'd0);
        bad = 0;
        repeat (20) begin
            if (tvalid_m | done_m | tlast_m | busy_m) bad++;
            step();
        end
        check("post_reset_quiet", bad, 0);
        ready = 1'b0;
    endtask

    localparam logic [95:0] A0 = {48'h0A0B0C0D0E0F, 48'h112233445566};
    localparam logic [95:0] A1 = {48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6};
    localparam logic [95:0] A2 = {48'h020000000001, 48'hFFFFFFFFFFFF};

    initial begin
        tbl[0]  = '{1'b0, A0, 16'd50,    100, 64,   16'h0032, 1'b0};
        tbl[1]  = '{1'b0, A1, 16'd10,    100, 60,   16'h000A, 1'b0};
        tbl[2]  = '{1'b0, A2, 16'd100,   50,  114,  16'h0064, 1'b0};
        tbl[3]  = '{1'b1, A0, 16'hFFFF,  100, 1514, 16'h05DC, 1'b0};
        tbl[4]  = '{1'b0, A1, 16'd0,     100, 60,   16'h0000, 1'b0};
        tbl[5]  = '{1'b0, A2, 16'd46,    60,  60,   16'h002E, 1'b0};
        tbl[6]  = '{1'b0, A0, 16'd47,    100, 61,   16'h002F, 1'b0};
        tbl[7]  = '{1'b0, A1, 16'd20,    100, 60,   16'h0014, 1'b1};
        tbl[8]  = '{1'b0, A2, 16'd20,    100, 60,   16'h0014, 1'b0};
        tbl[9]  = '{1'b1, A1, 16'd1501,  40,  1514, 16'h05DC, 1'b0};
        tbl[10] = '{1'b1, A2, 16'd1500,  100, 1514, 16'h05DC, 1'b0};
        tbl[11] = '{1'b1, A0, 16'd45,    100, 60,   16'h002D, 1'b0};

        rst_n = 1'b0; start = 1'b0; ready = 1'b0; sel = 1'b0;
        len_i = 16'd0; addr_i = '0;
        repeat (3) step();
        check("reset_a", {20'd0, tvalid_a, tlast_a, done_a, busy_a, tdata_a}, 32'd0);
        check("reset_b", {20'd0, tvalid_b, tlast_b, done_b, busy_b, tdata_b}, 32'd0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 12; i++) begin
            run_frame(tbl[i]);
            if (i == 0) check_basic_literal();
            if (i == 3) check_wrap_literal();
        end

        reset_mid_frame();
        run_frame(tbl[0]);
        check_basic_literal();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_frame_gen.md
Name: tx_frame_gen

Overview:
- Transmit frame generator downstream of the tx address register.
- On a start pulse it snapshots the 96-bit address word and a payload length, then emits one complete Ethernet frame as a byte-wide AXI4-Stream master toward the tri-mode MAC TX client interface.
- Frame layout: destination MAC, source MAC, 2-byte length field, then incrementing-pattern payload with zero padding to the 46-byte minimum.
- FCS and preamble are added by the MAC, not by this block.

Parameters:
- PAT_SEED, 8'h00, value of the first payload byte; each following byte increments by 1 (mod 256).
- IFG_CYCLES, 12, idle cycles enforced after each frame before a new start is accepted (range 0..255).
- MAX_PAYLOAD, 1500, upper clamp applied to the payload length.
- MIN_PAYLOAD, 46, minimum payload bytes on the wire; padding fills the shortfall.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  single-cycle request to send one frame
- payload_len  in  16  requested payload byte count, sampled on accepted start
- tx_address  in  96  [95:48] = source MAC, [47:0] = destination MAC, sampled on accepted start
- busy  out  1  high from accepted start until the IFG countdown ends
- done  out  1  one-cycle pulse on the tlast handshake
- m_axis_tdata  out  8  frame byte
- m_axis_tvalid  out  1  byte valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  last byte of the frame

Behaviour:
- Reset values (rst_n low at a clk edge):
  - state = IDLE
  - all outputs 0
  - internal snapshot registers and counters 0
  - Reset mid-frame aborts immediately; tvalid drops on the next cycle and no tlast is sent.
- Accepting a start:
  - start is accepted only in IDLE; it is ignored while busy, including during GAP.
  - On acceptance, capture the following, then go to DST:
    - addr_q = tx_address
    - len_q = min(payload_len, MAX_PAYLOAD)
    - If len_q = 0, the payload is all padding.
- Latency: start accepted at edge N -> tvalid = 1 with the first DST byte after edge N; busy = 1 in the same cycle.
- Outputs are registered. A byte advances only on a handshake (tvalid & tready). While tvalid = 1 and tready = 0, tdata and tlast hold stable. tvalid never drops mid-frame except on reset.
- States and byte sequence, using a byte counter cnt of 11 bits:
  - DST: 6 bytes, addr_q[47:40] first down to addr_q[7:0].
  - SRC: 6 bytes, addr_q[95:88] first down to addr_q[55:48].
  - LEN: 2 bytes, len_q[15:8] then len_q[7:0]. This is the unpadded clamped length.
  - PAY: total bytes = max(len_q, MIN_PAYLOAD).
    - Byte i (i from 0) = PAT_SEED + i[7:0] when i < len_q, else 8'h00.
    - tlast = 1 on the final PAY byte.
  - GAP: entered on the tlast handshake.
    - done = 1 for exactly that one cycle; tvalid = 0.
    - Counts IFG_CYCLES clock cycles, then IDLE, busy = 0.
    - IFG_CYCLES = 0 -> return to IDLE in the cycle after the tlast handshake.
- Frame length on the wire = 14 + max(len_q, 46) bytes; range 60..1514.
- Changes to tx_address or payload_len after acceptance have no effect on the frame in flight.
- The payload pattern wraps 8'hFF -> 8'h00 without disturbing cnt.

Test Plan:
- Basic frame, tready tied 1:
  - Stimulus: tx_address = {48'h0A0B0C0D0E0F, 48'h112233445566}, payload_len = 50, start pulse.
  - Required: 64 bytes, in order 11 22 33 44 55 66 0A 0B 0C 0D 0E 0F 00 32 00 01 .. 31.
  - tlast on byte 64; done one cycle later; busy low 12 cycles after done.
- Short frame:
  - Stimulus: payload_len = 10.
  - Required: length bytes 00 0A; payload 00..09 then 36 bytes of 00; 60 bytes total, tlast on byte 60.
- Backpressure:
  - Stimulus: random tready at 50% during a 100-byte frame.
  - Required: tdata/tlast stable across every stall; byte order identical to the tready = 1 run; 114 handshakes.
- Clamp and wrap:
  - Stimulus: payload_len = 16'hFFFF, PAT_SEED = 8'hF0.
  - Required: length field 05 DC; 1514 bytes; payload F0 .. FF 00 01 ...
- Start filtering:
  - Stimulus: start re-pulsed mid-frame and during GAP, with tx_address changed at the same time.
  - Required: both starts ignored; the current frame keeps its original addresses; a start in IDLE after the gap is accepted.
- Reset mid-frame:
  - Stimulus: rst_n low at byte 20 of the frame.
  - Required: all outputs 0 the next cycle; no done, no tlast; a new start afterwards produces a correct frame from the first DST byte.
